// File: rtl/vcve2_pkg.sv
// rtl/vcve2_pkg.sv - shared types and constants for the vector-capable cve2 core
//
// Holds the writeback-stage state encoding and the layout of the single
// instruction entry that the writeback stage keeps between ID/EX and the
// register file.

package vcve2_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RegAddrW = 5;

    // EMPTY     : no instruction held
    // ALU       : held result is final and retires this cycle
    // LOAD_WAIT : result arrives with the LSU response
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ALU       = 2'd1,
        LOAD_WAIT = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [RegAddrW-1:0] waddr;
        logic [XLEN-1:0]     wdata;
        logic                we;
        logic                is_load;
        logic                compressed;
        logic                perf_count;
    } wb_entry_t;

endpackage

// File: rtl/cve2_wb_stage.sv
// rtl/cve2_wb_stage.sv - registered single-entry writeback stage
//
// Holds one instruction between ID/EX and the register-file write port.
// ALU results are written one cycle after acceptance; loads are written in
// the cycle the LSU response arrives, and ID is held off until then.
//
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   en_wb_i / ready_wb_o             ID -> WB instruction handshake
//   flush_i                          drop a held non-load entry
//   instr_*_id_i, rf_*_id_i          instruction attributes and result from ID/EX
//   rf_wdata_lsu_i, lsu_resp_*_i     load response from the LSU
//   rf_waddr/wdata/we_wb_o           register-file write port
//   rf_write_pending_wb_o            held entry will write rf_waddr_wb_o
//   rf_wdata_fwd_wb_o                held ALU result for forwarding
//   outstanding_load_wb_o            waiting on a load response
//   perf_instr_ret*_wb_o             retire pulses

module cve2_wb_stage
    import vcve2_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter bit          SuppressX0   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    en_wb_i,
    output logic                    ready_wb_o,
    input  logic                    flush_i,

    input  logic                    instr_is_compressed_id_i,
    input  logic                    instr_perf_count_id_i,
    input  logic                    instr_is_load_id_i,
    input  logic [RegAddrWidth-1:0] rf_waddr_id_i,
    input  logic [DataWidth-1:0]    rf_wdata_id_i,
    input  logic                    rf_we_id_i,

    input  logic [DataWidth-1:0]    rf_wdata_lsu_i,
    input  logic                    lsu_resp_valid_i,
    input  logic                    lsu_resp_err_i,

    output logic [RegAddrWidth-1:0] rf_waddr_wb_o,
    output logic [DataWidth-1:0]    rf_wdata_wb_o,
    output logic                    rf_we_wb_o,
    output logic                    rf_write_pending_wb_o,
    output logic [DataWidth-1:0]    rf_wdata_fwd_wb_o,
    output logic                    outstanding_load_wb_o,
    output logic                    perf_instr_ret_wb_o,
    output logic                    perf_instr_ret_compressed_wb_o
);

    wb_state_e state_q, state_d;
    wb_entry_t entry_q, entry_d;

    logic done;
    logic accept;
    logic flush_alu;
    logic commit;
    logic load_err;
    logic x0_dst;

    // Entry leaves the stage this cycle.
    always_comb begin
        done = 1'b0;
        case (state_q)
            ALU:       done = 1'b1;
            LOAD_WAIT: done = lsu_resp_valid_i;
            default:   done = 1'b0;
        endcase
    end

    // A flushed ALU entry still leaves (done), but without side effects.
    // Loads are already committed to memory, so flush cannot touch them.
    assign flush_alu = (state_q == ALU) & flush_i;
    assign commit    = done & ~flush_alu;
    assign load_err  = (state_q == LOAD_WAIT) & lsu_resp_err_i;
    assign x0_dst    = SuppressX0 && (entry_q.waddr == '0);

    assign ready_wb_o = (state_q == EMPTY) | done;
    assign accept     = en_wb_i & ready_wb_o;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (accept) begin
            entry_d.waddr      = RegAddrW'(rf_waddr_id_i);
            entry_d.wdata      = XLEN'(rf_wdata_id_i);
            entry_d.we         = rf_we_id_i;
            entry_d.is_load    = instr_is_load_id_i;
            entry_d.compressed = instr_is_compressed_id_i;
            entry_d.perf_count = instr_perf_count_id_i;
            state_d            = instr_is_load_id_i ? LOAD_WAIT : ALU;
        end else if (done) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    assign rf_waddr_wb_o = RegAddrWidth'(entry_q.waddr);
    // Selected by state so a stray LSU bus value never leaks into an ALU write.
    assign rf_wdata_wb_o = (state_q == LOAD_WAIT) ? rf_wdata_lsu_i
                                                  : DataWidth'(entry_q.wdata);
    assign rf_wdata_fwd_wb_o = DataWidth'(entry_q.wdata);

    assign rf_we_wb_o            = commit & entry_q.we & ~load_err & ~x0_dst;
    assign rf_write_pending_wb_o = (state_q != EMPTY) & entry_q.we & ~x0_dst;
    assign outstanding_load_wb_o = (state_q == LOAD_WAIT);

    assign perf_instr_ret_wb_o            = commit & entry_q.perf_count & ~load_err;
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & entry_q.compressed;

    // ID must not present an instruction the stage cannot take.
    a_no_accept_when_busy : assert property (
        @(posedge clk_i) disable iff (!rst_ni) en_wb_i |-> ready_wb_o);

    // An LSU response is only meaningful while a load is outstanding.
    a_resp_only_in_load_wait : assert property (
        @(posedge clk_i) disable iff (!rst_ni) lsu_resp_valid_i |-> (state_q == LOAD_WAIT));

    a_write_implies_done : assert property (
        @(posedge clk_i) disable iff (!rst_ni) rf_we_wb_o |-> done);

endmodule

// File: tb/tb_cve2_wb_stage.sv
// tb/tb_cve2_wb_stage.sv - self-checking bench for cve2_wb_stage

module tb_cve2_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, rdy, flush, comp, perf, isld, we_in;
    logic [4:0]  waddr_in;
    logic [31:0] wdata_in, ldata;
    logic        rvalid, rerr;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, fwd_o;
    logic        we_o, pend_o, outst_o, ret_o, retc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cve2_wb_stage dut (
        .clk_i                          (clk),
        .rst_ni                         (rst_n),
        .en_wb_i                        (en),
        .ready_wb_o                     (rdy),
        .flush_i                        (flush),
        .instr_is_compressed_id_i       (comp),
        .instr_perf_count_id_i          (perf),
        .instr_is_load_id_i             (isld),
        .rf_waddr_id_i                  (waddr_in),
        .rf_wdata_id_i                  (wdata_in),
        .rf_we_id_i                     (we_in),
        .rf_wdata_lsu_i                 (ldata),
        .lsu_resp_valid_i               (rvalid),
        .lsu_resp_err_i                 (rerr),
        .rf_waddr_wb_o                  (waddr_o),
        .rf_wdata_wb_o                  (wdata_o),
        .rf_we_wb_o                     (we_o),
        .rf_write_pending_wb_o          (pend_o),
        .rf_wdata_fwd_wb_o              (fwd_o),
        .outstanding_load_wb_o          (outst_o),
        .perf_instr_ret_wb_o            (ret_o),
        .perf_instr_ret_compressed_wb_o (retc_o)
    );

    typedef struct {
        logic        r, e, l, c, p, w;
        logic [4:0]  a;
        logic [31:0] d;
        logic        f, v, x;
        logic [31:0] ld;
        logic        x_rdy, x_we;
        logic [4:0]  x_a;
        logic [31:0] x_d;
        logic        x_pend, x_outst, x_ret, x_retc, chk_ad;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        w, ld, c, p;
    } rec_t;

    vec_t vt[$];
    rec_t model[$];

    function automatic vec_t mk(
        input logic r, e, l, c, p, w, input logic [4:0] a, input logic [31:0] d,
        input logic f, v, x, input logic [31:0] ld,
        input logic rd, we, input logic [4:0] ea, input logic [31:0] ed,
        input logic pe, ou, rt, rc, ck);
        vec_t t;
        t.r = r; t.e = e; t.l = l; t.c = c; t.p = p; t.w = w; t.a = a; t.d = d;
        t.f = f; t.v = v; t.x = x; t.ld = ld;
        t.x_rdy = rd; t.x_we = we; t.x_a = ea; t.x_d = ed;
        t.x_pend = pe; t.x_outst = ou; t.x_ret = rt; t.x_retc = rc; t.chk_ad = ck;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, e, l, c, p, w, input logic [4:0] a,
                         input logic [31:0] d, input logic f, v, x, input logic [31:0] ld);
        rst_n = r; en = e; isld = l; comp = c; perf = p; we_in = w;
        waddr_in = a; wdata_in = d; flush = f; rvalid = v; rerr = x; ldata = ld;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0);

        //         r e l c p w  a   d             f v x  ld          rdy we ea  ed            pe ou rt rc ck
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,1));
        vt.push_back(mk(1,1,0,0,1,1, 5, 32'hDEADBEEF, 0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,1));
        vt.push_back(mk(1,1,0,1,1,1, 6, 32'h66,       0,0,0, 32'h0,       1,1, 5, 32'hDEADBEEF, 1,0,1,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,1, 6, 32'h66,       1,0,1,1,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        // load to x7, response three cycles after accept, new accept in same cycle
        vt.push_back(mk(1,1,1,0,1,1, 7, 32'hAAAA,     0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h5555,    0,0, 7, 32'h5555,     1,1,0,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       0,0, 0, 32'h0,        1,1,0,0,0));
        vt.push_back(mk(1,1,0,0,1,1, 8, 32'h88,       0,1,0, 32'h1234,    1,1, 7, 32'h1234,     1,1,1,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,1, 8, 32'h88,       1,0,1,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        // load error
        vt.push_back(mk(1,1,1,1,1,1, 9, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,1,1, 32'hBAD,     1,0, 9, 32'hBAD,      1,1,0,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        // x0 destination
        vt.push_back(mk(1,1,0,1,1,1, 0, 32'h77,       0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h77,       0,0,1,1,1));
        // flush while empty, then flush in ALU with a same-cycle accept
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        1,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,1,0,0,1,1,10, 32'hA,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,1,0,0,1,1,11, 32'hB,        1,0,0, 32'h0,       1,0, 0, 32'h0,        1,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,1,11, 32'hB,        1,0,1,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        // flush in LOAD_WAIT is ignored
        vt.push_back(mk(1,1,1,0,1,1,12, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        1,0,0, 32'h0,       0,0, 0, 32'h0,        1,1,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,1,0, 32'hC0DE,    1,1,12, 32'hC0DE,     1,1,1,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        // reset during LOAD_WAIT, stray response while reset is held
        vt.push_back(mk(1,1,1,0,1,1,13, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       0,0, 0, 32'h0,        1,1,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0, 0, 32'h0,        0,1,0, 32'hFFFF,    1,0, 0, 32'h0,        0,0,0,0,1));
        vt.push_back(mk(1,0,0,0,0,0, 0, 32'h0,        0,0,0, 32'h0,       1,0, 0, 32'h0,        0,0,0,0,1));

        repeat (3) @(negedge clk);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].r, vt[i].e, vt[i].l, vt[i].c, vt[i].p, vt[i].w, vt[i].a, vt[i].d,
                  vt[i].f, vt[i].v, vt[i].x, vt[i].ld);
            #1;
            chk($sformatf("vec%0d ready", i), 32'(rdy),     32'(vt[i].x_rdy));
            chk($sformatf("vec%0d we", i),    32'(we_o),    32'(vt[i].x_we));
            chk($sformatf("vec%0d pend", i),  32'(pend_o),  32'(vt[i].x_pend));
            chk($sformatf("vec%0d outst", i), 32'(outst_o), 32'(vt[i].x_outst));
            chk($sformatf("vec%0d ret", i),   32'(ret_o),   32'(vt[i].x_ret));
            chk($sformatf("vec%0d retc", i),  32'(retc_o),  32'(vt[i].x_retc));
            if (vt[i].chk_ad) begin
                chk($sformatf("vec%0d waddr", i), 32'(waddr_o), 32'(vt[i].x_a));
                chk($sformatf("vec%0d wdata", i), wdata_o,      vt[i].x_d);
            end
        end

        // Randomized traffic against a queue-based model of the stage.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic has, il, rv, er, fl, dn, drop, cm, rd, e;
            logic x_we, x_ret;
            rec_t h, n;
            @(negedge clk);
            has = (model.size() > 0);
            if (has) h = model[0];
            else     h = '{a: 5'd0, d: 32'h0, w: 1'b0, ld: 1'b0, c: 1'b0, p: 1'b0};
            il   = has && h.ld;
            rv   = il && ($urandom_range(0, 2) == 0);
            er   = rv && ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 7) == 0);
            dn   = has && (!il || rv);
            drop = has && !il && fl;
            cm   = dn && !drop;
            rd   = !has || dn;
            e    = rd && ($urandom_range(0, 1) == 0);
            n.a  = 5'($urandom_range(0, 31));
            n.d  = $urandom();
            n.w  = ($urandom_range(0, 3) != 0);
            n.ld = ($urandom_range(0, 2) == 0);
            n.c  = ($urandom_range(0, 1) == 0);
            n.p  = ($urandom_range(0, 3) != 0);
            drive(1, e, n.ld, n.c, n.p, n.w, n.a, n.d, fl, rv, er, $urandom());
            #1;
            x_we  = cm && h.w && !(il && er) && (h.a != 0);
            x_ret = cm && h.p && !(il && er);
            chk("rnd ready", 32'(rdy),     32'(rd));
            chk("rnd we",    32'(we_o),    32'(x_we));
            chk("rnd pend",  32'(pend_o),  32'(has && h.w && (h.a != 0)));
            chk("rnd outst", 32'(outst_o), 32'(il));
            chk("rnd ret",   32'(ret_o),   32'(x_ret));
            chk("rnd retc",  32'(retc_o),  32'(x_ret && h.c));
            if (x_we) begin
                chk("rnd waddr", 32'(waddr_o), 32'(h.a));
                chk("rnd wdata", wdata_o, il ? ldata : h.d);
            end
            if (has && !il) chk("rnd fwd", fwd_o, h.d);
            @(posedge clk);
            if (dn) void'(model.pop_front());
            if (e)  model.push_back(n);
        end

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
